// File: rtl/aes_shiftmix_stage.sv
// AES round middle stage: ShiftRows then (unless in_last) MixColumns, registered with valid/ready.
// Define AES_SHIFTMIX_SKID_EN for a 2-entry buffer with a registered in_ready.
module aes_shiftmix_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Column bytes are packed row 0 in the MSBs.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    logic [127:0] sr_state;
    logic [127:0] mc_state;
    logic [127:0] xf_state;

    always_comb begin
        sr_state = shift_rows(in_state);
        mc_state = {mix_col(sr_state[127:96]), mix_col(sr_state[95:64]),
                    mix_col(sr_state[63:32]),  mix_col(sr_state[31:0])};
        xf_state = in_last ? sr_state : mc_state;
    end

    logic         out_valid_q, out_valid_d;
    logic [127:0] out_state_q, out_state_d;
    logic         out_last_q,  out_last_d;
    logic         accept;
    logic         pop;

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_last  = out_last_q;

`ifdef AES_SHIFTMIX_SKID_EN
    logic         skid_valid_q, skid_valid_d;
    logic [127:0] skid_state_q, skid_state_d;
    logic         skid_last_q,  skid_last_d;
    logic         in_ready_q,   in_ready_d;

    assign in_ready = in_ready_q;

    // in_ready_q mirrors "skid empty", so an accept never coincides with a full skid entry.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_state_d  = out_state_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_state_d = skid_state_q;
        skid_last_d  = skid_last_q;
        accept       = in_valid && in_ready_q;
        pop          = out_valid_q && out_ready;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_state_d  = skid_state_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_state_d = xf_state;
                    out_last_d  = in_last;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_state_d = xf_state;
            skid_last_d  = in_last;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_state_q  <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_state_q <= '0;
            skid_last_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_state_q  <= out_state_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_state_q <= skid_state_d;
            skid_last_q  <= skid_last_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    always_comb begin
        in_ready    = rst_n && (!out_valid_q || out_ready);
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_last_d  = out_last_q;
        accept      = in_valid && in_ready;
        pop         = out_valid_q && out_ready;
        if (accept) begin
            out_valid_d = 1'b1;
            out_state_d = xf_state;
            out_last_d  = in_last;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_last_q  <= out_last_d;
        end
    end
`endif

endmodule

// File: doc/aes_shiftmix_stage.md
AES_SHIFTMIX_STAGE -- requirements
Module: aes_shiftmix_stage

Interface
REQ-001 Parameters: none; the block SHALL be fixed at a 128-bit state width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream (SubBytes output) word valid.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_state  input  128  post-SubBytes state; byte i = in_state[127-8i -: 8], column-major (byte i = row i%4, col i/4).
REQ-007 in_last  input  1  final round: skip MixColumns.
REQ-008 out_valid  output  1  out_state/out_last valid.
REQ-009 out_ready  input  1  downstream (AddRoundKey) accepts.
REQ-010 out_state  output  128  transformed state, same byte ordering.
REQ-011 out_last  output  1  in_last of the word presented.

Function
REQ-012 Input transfer SHALL occur when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready.
REQ-013 ShiftRows: output byte (r,c) SHALL equal input byte (r,(c+r) mod 4).
REQ-014 MixColumns SHALL be applied after ShiftRows when in_last=0: per column, GF(2^8) multiply by {02,03,01,01} circulant, reduction polynomial 0x11B, xtime = (b<<1) ^ (b[7] ? 0x1B : 0).
REQ-015 When in_last=1, out_state SHALL be the ShiftRows result only.
REQ-016 The transform SHALL be computed combinationally on the input side and registered; latency 1 cycle: word accepted at edge N is on out_state with out_valid=1 after edge N.
REQ-017 Words SHALL leave in acceptance order; none dropped or duplicated.
REQ-018 While out_valid=1 and out_ready=0, out_state and out_last SHALL hold stable.
REQ-019 out_valid SHALL not depend combinationally on in_valid.
REQ-020 Simultaneous input and output transfer in the same cycle SHALL be supported with no bubble (sustained 1 word/cycle when out_ready=1).
REQ-021 in_valid with in_ready=0: no state change; upstream holds data (its obligation).
REQ-022 out_state when out_valid=0 is don't-care for downstream; bench SHALL not check it.

Reset
REQ-023 When rst_n=0 at a rising edge: out_valid=0, out_last=0, out_state=128'h0, all buffered entries invalidated.
REQ-024 Input transfers coinciding with rst_n=0 SHALL be discarded.
REQ-025 Reset mid-stream SHALL drop all in-flight words; first edge with rst_n=1 resumes normal acceptance.

Configuration
REQ-026 Macro AES_SHIFTMIX_SKID_EN defined: 2-entry buffer (output register + skid register); in_ready SHALL be a register output (= skid entry empty), no combinational path out_ready->in_ready; in_ready=0 after reset edge held low, 1 on first edge with rst_n=1; on stall a word accepted while output is blocked SHALL go to the skid entry and drain first-in-first-out.
REQ-027 Macro undefined: single output register; in_ready = !out_valid || out_ready (combinational), forced 0 while rst_n=0.
REQ-028 Both builds SHALL produce identical output data sequences for identical accepted input sequences.

Verification
REQ-029 in_state=d42711aee0bf98f1b8b45de51e415230, in_last=0, out_ready=1 -> next cycle out_state=046681e5e0cb199a48f8d37a2806264c, out_last=0.
REQ-030 in_state=e9098972cb31075f3d327d94af2e2cb5, in_last=1 -> out_state=e9317db5cb322c723d2e895faf090794, out_last=1.
REQ-031 Back-to-back 8 words, out_ready=1 continuously -> 8 consecutive out_valid cycles, correct order, zero bubbles.
REQ-032 out_ready=0 for 5 cycles with in_valid=1 -> out_state stable; accepted count = 1 (macro off) / 2 (macro on); release -> all accepted words emerge in order, none lost.
REQ-033 rst_n=0 for 1 cycle while 2 words buffered -> out_valid=0 next cycle, buffered words never appear; new word after reset processed with 1-cycle latency.
REQ-034 Random stimulus, random in_valid/out_ready, both macro settings -> output stream matches software ShiftRows/MixColumns model, handshake rules REQ-012..REQ-020 asserted every cycle.
